// File: rtl/ras_stack_pkg.sv
// rtl/ras_stack_pkg.sv - shared types and sizing for the return-address stack
package ras_stack_pkg;

    localparam int RasDepth = 8;
    localparam int RasIdx   = $clog2(RasDepth);
    localparam int RasXlen  = 32;

    typedef struct packed {
        logic               push;
        logic               pop;
        logic [RasXlen-1:0] ra;
    } ras_update_t;

    typedef struct packed {
        logic               valid;
        logic [RasXlen-1:0] ra;
    } ras_predict_t;

    typedef struct packed {
        logic [RasIdx-1:0]  tos;
        logic [RasIdx:0]    count;
        logic [RasXlen-1:0] top_ra;
    } ras_ckpt_t;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ras_stack_if.sv
// rtl/ras_stack_if.sv - predecoder/BJU facing bundle of the return-address stack
interface ras_stack_if;
    import ras_stack_pkg::*;

    ras_update_t  update;
    ras_predict_t predict;
    ras_ckpt_t    ckpt;
    logic         recover;
    ras_ckpt_t    ckpt_restore;
    logic         flush;

    modport master (
        output update, recover, ckpt_restore, flush,
        input  predict, ckpt
    );

    modport slave (
        input  update, recover, ckpt_restore, flush,
        output predict, ckpt
    );
endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with overflow overwrite and checkpoint repair
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int Depth = RasDepth
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    ras_stack_if.slave  ras
);

    localparam int             Idx    = $clog2(Depth);
    localparam logic [Idx:0]   DepthC = Depth[Idx:0];

    logic [RasXlen-1:0] mem [Depth];
    logic [Idx-1:0]     tos;
    logic [Idx:0]       count;
    logic [Idx-1:0]     tos_inc;

    assign tos_inc = tos + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else if (ras.flush) begin
            tos   <= '0;
            count <= '0;
        end else if (ras.recover) begin
            // A wrong-path push may have clobbered the checkpointed top slot.
            tos                        <= ras.ckpt_restore.tos;
            count                      <= ras.ckpt_restore.count;
            mem[ras.ckpt_restore.tos]  <= ras.ckpt_restore.top_ra;
        end else if (ras.update.push && ras.update.pop) begin
            mem[tos] <= ras.update.ra;
            if (count == '0) count <= 1;
        end else if (ras.update.push) begin
            // When full the write lands on the oldest entry and count saturates.
            tos          <= tos_inc;
            mem[tos_inc] <= ras.update.ra;
            if (count != DepthC) count <= count + 1'b1;
        end else if (ras.update.pop && count != '0) begin
            tos   <= tos - 1'b1;
            count <= count - 1'b1;
        end
    end

    always_comb begin
        ras.predict       = '0;
        ras.predict.valid = (count != '0);
        ras.predict.ra    = (count != '0) ? mem[tos] : '0;
        ras.ckpt          = '0;
        ras.ckpt.tos      = tos;
        ras.ckpt.count    = count;
        ras.ckpt.top_ra   = mem[tos];
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (is_pow2(Depth) && Depth == RasDepth);
            assert (count <= DepthC);
            if (!ras.flush && !ras.recover && ras.update.push)
                assert (!$isunknown(ras.update.ra));
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - randomized bench for ras_stack against a behavioural stack model
module tb_ras_stack;
    import ras_stack_pkg::*;

    localparam int D = RasDepth;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    ras_stack_if bus ();

    ras_stack #(.Depth(D)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ras    (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference: circular slot array with a top index and a live-entry count.
    int          m_tos;
    int          m_cnt;
    logic [31:0] m_mem [D];

    ras_ckpt_t   hist [8];
    int          n_hist = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ras_ckpt_t model_ckpt();
        ras_ckpt_t c;
        c.tos    = RasIdx'(m_tos);
        c.count  = (RasIdx + 1)'(m_cnt);
        c.top_ra = m_mem[m_tos];
        return c;
    endfunction

    task automatic model_reset();
        m_tos = 0;
        m_cnt = 0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    task automatic model_step(input logic push, input logic pop, input logic [31:0] ra,
                              input logic rec, input ras_ckpt_t ck, input logic fl);
        if (fl) begin
            m_tos = 0;
            m_cnt = 0;
        end else if (rec) begin
            m_tos = int'(ck.tos);
            m_cnt = int'(ck.count);
            m_mem[m_tos] = ck.top_ra;
        end else if (push && pop) begin
            m_mem[m_tos] = ra;
            if (m_cnt < 1) m_cnt = 1;
        end else if (push) begin
            m_tos = (m_tos + 1) % D;
            m_mem[m_tos] = ra;
            if (m_cnt < D) m_cnt = m_cnt + 1;
        end else if (pop && m_cnt > 0) begin
            m_tos = (m_tos + D - 1) % D;
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".valid"}, 64'(bus.predict.valid), 64'(m_cnt != 0));
        check_val({tag, ".ra"},    64'(bus.predict.ra),    64'((m_cnt != 0) ? m_mem[m_tos] : 32'h0));
        check_val({tag, ".tos"},   64'(bus.ckpt.tos),      64'(m_tos));
        check_val({tag, ".count"}, 64'(bus.ckpt.count),    64'(m_cnt));
        check_val({tag, ".top"},   64'(bus.ckpt.top_ra),   64'(m_mem[m_tos]));
    endtask

    // Drives one cycle of inputs, advances the model past the edge, then samples.
    task automatic step(input string tag, input logic push, input logic pop, input logic [31:0] ra,
                        input logic rec, input ras_ckpt_t ck, input logic fl);
        bus.update.push   = push;
        bus.update.pop    = pop;
        bus.update.ra     = ra;
        bus.recover       = rec;
        bus.ckpt_restore  = ck;
        bus.flush         = fl;
        @(posedge clk_i);
        model_step(push, pop, ra, rec, ck, fl);
        #1;
        bus.update   = '0;
        bus.recover  = 1'b0;
        bus.flush    = 1'b0;
        check_state(tag);
    endtask

    task automatic push_op(input string tag, input logic [31:0] ra);
        step(tag, 1'b1, 1'b0, ra, 1'b0, '0, 1'b0);
    endtask

    task automatic pop_op(input string tag);
        step(tag, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic flush_op();
        step("flush", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        ras_ckpt_t ck;
        bus.update       = '0;
        bus.recover      = 1'b0;
        bus.ckpt_restore = '0;
        bus.flush        = 1'b0;
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_state("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic push/pop order
        push_op("p1", 32'h8000_0010);
        push_op("p2", 32'h8000_0020);
        check_val("p2.top_const", 64'(bus.predict.ra), 64'h8000_0020);
        pop_op("pop1");
        check_val("pop1.top_const", 64'(bus.predict.ra), 64'h8000_0010);
        pop_op("pop2");
        check_val("pop2.empty", 64'(bus.predict.valid), 64'h0);
        check_val("pop2.ra0", 64'(bus.predict.ra), 64'h0);

        // Overflow: ten pushes into eight slots
        for (int i = 0; i < 10; i++) push_op("ovf.push", 32'hA000_0000 + 32'(i * 4));
        check_val("ovf.count", 64'(bus.ckpt.count), 64'(D));
        for (int k = 0; k < 8; k++) begin
            check_val("ovf.order", 64'(bus.predict.ra), 64'(32'hA000_0000 + 32'((9 - k) * 4)));
            pop_op("ovf.pop");
        end
        check_val("ovf.drained", 64'(bus.predict.valid), 64'h0);
        pop_op("underflow");
        check_val("underflow.count", 64'(bus.ckpt.count), 64'h0);

        // Same-cycle push+pop replaces the top
        flush_op();
        push_op("pp.a", 32'h80);
        push_op("pp.b", 32'h90);
        push_op("pp.c", 32'h100);
        step("pp", 1'b1, 1'b1, 32'h200, 1'b0, '0, 1'b0);
        check_val("pp.top", 64'(bus.predict.ra), 64'h200);
        check_val("pp.count", 64'(bus.ckpt.count), 64'h3);
        pop_op("pp.pop");
        check_val("pp.second", 64'(bus.predict.ra), 64'h90);

        // Checkpoint repair after a wrong-path pop+push
        flush_op();
        push_op("ck.a", 32'h100);
        push_op("ck.b", 32'h200);
        push_op("ck.c", 32'h300);
        ck = model_ckpt();
        pop_op("ck.pop");
        push_op("ck.wrong", 32'h999);
        check_val("ck.clobbered", 64'(bus.predict.ra), 64'h999);
        step("ck.rec", 1'b0, 1'b0, '0, 1'b1, ck, 1'b0);
        check_val("ck.top", 64'(bus.predict.ra), 64'h300);
        check_val("ck.count", 64'(bus.ckpt.count), 64'h3);
        pop_op("ck.pop2");
        check_val("ck.below", 64'(bus.predict.ra), 64'h200);

        // Priority: recover beats push, flush beats recover
        step("rec_vs_push", 1'b1, 1'b0, 32'h5555, 1'b1, ck, 1'b0);
        check_val("rec_vs_push.top", 64'(bus.predict.ra), 64'h300);
        step("flush_vs_rec", 1'b1, 1'b0, 32'h6666, 1'b1, ck, 1'b1);
        check_val("flush_vs_rec.valid", 64'(bus.predict.valid), 64'h0);

        // Async reset away from the clock edge
        push_op("ar.a", 32'h1234);
        bus.update.push = 1'b1;
        bus.update.ra   = 32'h4321;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_val("areset.valid", 64'(bus.predict.valid), 64'h0);
        check_val("areset.ra", 64'(bus.predict.ra), 64'h0);
        check_val("areset.count", 64'(bus.ckpt.count), 64'h0);
        bus.update = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_state("after_reset");

        // Random mix of push/pop/push+pop/recover/flush
        for (int n = 0; n < 600; n++) begin
            int   r;
            logic fl, rec;
            r   = int'($urandom_range(0, 99));
            fl  = (r < 3);
            rec = (r >= 3 && r < 11 && n_hist > 0);
            if ($urandom_range(0, 3) == 0) begin
                hist[$urandom_range(0, 7)] = model_ckpt();
                if (n_hist < 8) n_hist++;
            end
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 rec, hist[$urandom_range(0, (n_hist > 0) ? n_hist - 1 : 0)], fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
    end

endmodule
